// File: rtl/mul_div_unit.sv
// Multi-cycle signed WIDTHxWIDTH multiplier / WIDTH/WIDTH divider with a start/busy/done handshake.
// MUL returns the full 2*WIDTH product; DIV returns {remainder, quotient}.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               div_zero_o,
    output logic [2*WIDTH-1:0] zout_o
);

    localparam int unsigned ZW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            op_q, op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;
    logic [ZW-1:0]   zout_q, zout_d;

    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [ZW-1:0]    product;
    logic [WIDTH-1:0] quo_s, rem_s, a_orig;

    assign a_mag_in = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag_in = b_i[WIDTH-1] ? -b_i : b_i;

    // MUL step: add multiplicand when the low multiplier bit is set, then shift the pair right
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});

    // DIV step: restoring division; hi holds the partial remainder, lo shifts dividend out / quotient in
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b_q};
    assign div_diff  = WIDTH'(div_shift - {1'b0, mag_b_q});

    assign product = {hi_q, lo_q};
    assign quo_s   = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    assign rem_s   = sign_a_q ? -hi_q : hi_q;
    assign a_orig  = sign_a_q ? -mag_a_q : mag_a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            zout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            zout_q   <= zout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        zout_d   = zout_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    sign_a_d = a_i[WIDTH-1];
                    sign_b_d = b_i[WIDTH-1];
                    mag_a_d  = a_mag_in;
                    mag_b_d  = b_mag_in;
                    hi_d     = '0;
                    lo_d     = op_i ? a_mag_in : b_mag_in;
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (!op_q) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                if (!op_q) begin
                    zout_d = (sign_a_q ^ sign_b_q) ? -product : product;
                    dz_d   = 1'b0;
                end else if (mag_b_q == '0) begin
                    // Divide by zero: echo the dividend with an all-ones quotient
                    zout_d = {a_orig, {WIDTH{1'b1}}};
                    dz_d   = 1'b1;
                end else begin
                    zout_d = {rem_s, quo_s};
                    dz_d   = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign zout_o     = zout_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops against a plain-arithmetic model.
module tb_mul_div_unit;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = 33;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic              op_i;
    logic [WIDTH-1:0]  a_i;
    logic [WIDTH-1:0]  b_i;
    logic              busy_o;
    logic              done_o;
    logic              div_zero_o;
    logic [2*WIDTH-1:0] zout_o;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .zout_o     (zout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Signed arithmetic reference: truncating division, remainder follows the dividend
    function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] z, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (!op) begin
            p  = sa * sb;
            z  = p;
            dz = 1'b0;
        end else if (b == 32'h0) begin
            z  = {a, 32'hFFFF_FFFF};
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            z  = {r[31:0], q[31:0]};
            dz = 1'b0;
        end
    endfunction

    // Issue one op starting at a negedge; returns at the negedge of the following IDLE cycle
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input int glitch);
        logic [63:0] ez;
        logic        edz;
        int          cyc;
        bit          busy_ok;
        model(op, a, b, ez, edz);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        op_i    = ~op;
        cyc     = 0;
        busy_ok = 1'b1;
        while (!done_o && cyc < 60) begin
            if (!busy_o) busy_ok = 1'b0;
            if (cyc == glitch) begin
                start_i = 1'b1;
                a_i     = $urandom;
                b_i     = $urandom;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        if (!done_o) begin
            check("done_timeout", 64'(cyc), 64'(LATENCY));
            return;
        end
        check("latency", 64'(cyc), 64'(LATENCY));
        check("busy_during_op", 64'(busy_ok), 64'(1));
        check("busy_with_done", 64'(busy_o), 64'(1));
        check("zout", zout_o, ez);
        check("div_zero", 64'(div_zero_o), 64'(edz));
        @(negedge clk);
        check("done_pulse_end", 64'(done_o), 64'(0));
        check("busy_idle", 64'(busy_o), 64'(0));
        check("zout_hold", zout_o, ez);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #12;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_div_zero", 64'(div_zero_o), 64'(0));
        check("rst_zout", zout_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back-to-back
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1);
        check("mul_7_m3_const", zout_o, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1);
        check("mul_min_min_const", zout_o, 64'h4000_0000_0000_0000);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_m7_2_const", zout_o, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1);
        check("div_7_m2_const", zout_o, 64'h0000_0001_FFFF_FFFD);
        run_op(1'b1, 32'd5, 32'd0, -1);
        check("div_5_0_const", zout_o, 64'h0000_0005_FFFF_FFFF);
        run_op(1'b0, 32'd2, 32'd3, -1);
        check("dz_cleared", 64'(div_zero_o), 64'(0));
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div_overflow_const", zout_o, 64'h0000_0000_8000_0000);
        run_op(1'b0, 32'd1234, 32'hFFFF_0000, 10);
        run_op(1'b1, 32'h8000_0000, 32'd0, -1);

        // Reset in the middle of a DIV
        start_i = 1'b1;
        op_i    = 1'b1;
        a_i     = 32'd1000;
        b_i     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_done", 64'(done_o), 64'(0));
        check("midrst_div_zero", 64'(div_zero_o), 64'(0));
        check("midrst_zout", zout_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b1, 32'd1000, 32'd7, -1);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
